// File: rtl/mel_fbank_seq.sv
// ============================================================================
// Module   : mel_fbank_seq
// Purpose  : Frame sequencer that streams FFT bins, weight pairs and mac bits
//            to the mel filterbank datapath and tracks returned mel outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mel_fbank_seq #(
    parameter int WIDTH     = 16,
    parameter int N_MEL     = 40,
    parameter int N_BINS    = 257,
    parameter int DRAIN_MAX = 16,
    parameter int AW        = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               hold,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_err,
    output logic [5:0]         mel_idx,
    output logic               rd_en,
    output logic [AW-1:0]      rd_addr,
    input  logic [WIDTH-1:0]   fft_rdata,
    input  logic [2*WIDTH-1:0] coef_rdata,
    input  logic [1:0]         mac_rdata,
    output logic               fft_bin_vld,
    output logic [WIDTH-1:0]   fft_bin,
    output logic [2*WIDTH-1:0] mel_fbank_weight,
    output logic [1:0]         mac_bits,
    output logic [AW-1:0]      fft_bin_idx,
    input  logic               mel_spec_vld
);

    localparam int DCW = $clog2(DRAIN_MAX) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0]  LAST_ADDR  = AW'(N_BINS - 1);
    localparam logic [5:0]     MEL_FULL   = 6'(N_MEL);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

    logic [1:0]     state_q,     state_d;
    logic [AW-1:0]  rd_addr_q,   rd_addr_d;
    logic [5:0]     mel_idx_q,   mel_idx_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           frame_err_q, frame_err_d;
    logic           bin_vld_q;
    logic [AW-1:0]  bin_idx_q;

    logic w_rd_en;
    logic w_active;
    logic w_mel_full;

    assign w_rd_en    = (state_q == S_ISSUE) && !hold;
    assign w_active   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign w_mel_full = (mel_idx_q == MEL_FULL);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        mel_idx_d   = mel_idx_q;
        drain_cnt_d = drain_cnt_q;
        frame_err_d = frame_err_q;

        // Mel outputs are counted before the drain exit decision below.
        if (w_active && mel_spec_vld) begin
            if (w_mel_full) begin
                frame_err_d = 1'b1;
            end else begin
                mel_idx_d = mel_idx_q + 6'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d     = S_ISSUE;
                    rd_addr_d   = '0;
                    mel_idx_d   = '0;
                    drain_cnt_d = '0;
                    frame_err_d = 1'b0;
                end
            end
            S_ISSUE: begin
                if (w_rd_en) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (w_mel_full) begin
                    state_d = S_DONE;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    if (mel_idx_d != MEL_FULL) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            mel_idx_q   <= '0;
            drain_cnt_q <= '0;
            frame_err_q <= 1'b0;
            bin_vld_q   <= 1'b0;
            bin_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            mel_idx_q   <= mel_idx_d;
            drain_cnt_q <= drain_cnt_d;
            frame_err_q <= frame_err_d;
            bin_vld_q   <= w_rd_en;
            bin_idx_q   <= rd_addr_q;
        end
    end

    // Memory data arrives one cycle after rd_en, aligned with the registered valid.
    assign fft_bin          = fft_rdata;
    assign mel_fbank_weight = coef_rdata;
    assign mac_bits         = mac_rdata;

    assign busy        = w_active;
    assign frame_done  = (state_q == S_DONE);
    assign frame_err   = frame_err_q;
    assign mel_idx     = mel_idx_q;
    assign rd_en       = w_rd_en;
    assign rd_addr     = rd_addr_q;
    assign fft_bin_vld = bin_vld_q;
    assign fft_bin_idx = bin_idx_q;

endmodule

`default_nettype wire
